// File: rtl/pipelined_mac.sv
// Pipelined WIDTH x WIDTH multiplier with per-sample signedness,
// optional accumulator and sticky overflow flag.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   in_valid        sample strobe for a, b and sideband
//   a, b            WIDTH-bit operands
//   signed_mode     1 = two's complement, 0 = unsigned
//   acc_en, acc_clr accumulate / load-accumulator controls
//   out_valid       product/acc valid, STAGES cycles after capture
//   product         full-precision 2*WIDTH product
//   acc, acc_ovf    running accumulator and sticky overflow
module pipelined_mac #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  localparam int PW = 2*WIDTH;

  typedef struct packed {
    logic             vld;
    logic             sm;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cap_t;

  typedef struct packed {
    logic          vld;
    logic          sm;
    logic          en;
    logic          clr;
    logic [PW-1:0] p;
  } prd_t;

  cap_t cap_q;
  prd_t mul_s;
  prd_t fin_s;

  // Operand word is only reloaded for valid samples; the valid
  // bit itself follows in_valid every cycle so bubbles propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (in_valid) begin
      cap_q <= '{vld: 1'b1, sm: signed_mode, en: acc_en,
                 clr: acc_clr, a: a, b: b};
    end else begin
      cap_q.vld <= 1'b0;
    end
  end

  // Extending to PW bits before a PW-bit multiply gives the exact
  // product in both modes; the low PW bits are all that matter.
  logic [PW-1:0] ea_s;
  logic [PW-1:0] eb_s;

  always_comb begin
    if (cap_q.sm) begin
      ea_s = PW'($signed(cap_q.a));
      eb_s = PW'($signed(cap_q.b));
    end else begin
      ea_s = PW'(cap_q.a);
      eb_s = PW'(cap_q.b);
    end
    mul_s = '{vld: cap_q.vld, sm: cap_q.sm, en: cap_q.en,
              clr: cap_q.clr, p: ea_s * eb_s};
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign fin_s = mul_s;
    end else begin : g_pipe
      prd_t pipe_q [STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES-1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= mul_s;
          for (int i = 1; i < STAGES-1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign fin_s = pipe_q[STAGES-2];
    end
  endgenerate

  logic                 vld_q;
  logic [PW-1:0]        prod_q;
  logic [PW-1:0]        prod_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [ACC_WIDTH-1:0] ext_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 add_ovf_s;

  always_comb begin
    if (fin_s.sm) begin
      ext_s = ACC_WIDTH'($signed(fin_s.p));
    end else begin
      ext_s = ACC_WIDTH'(fin_s.p);
    end
    sum_s = {1'b0, acc_q} + {1'b0, ext_s};
    // Signed: like-signed addends with a differing result sign.
    // Unsigned: carry out of the top bit.
    if (fin_s.sm) begin
      add_ovf_s = (acc_q[ACC_WIDTH-1] == ext_s[ACC_WIDTH-1]) &&
                  (sum_s[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      add_ovf_s = sum_s[ACC_WIDTH];
    end

    prod_d = prod_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (fin_s.vld) begin
      prod_d = fin_s.p;
      if (fin_s.en) begin
        if (fin_s.clr) begin
          acc_d = ext_s;
          ovf_d = 1'b0;
        end else begin
          acc_d = sum_s[ACC_WIDTH-1:0];
          ovf_d = ovf_q | add_ovf_s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= fin_s.vld;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign product   = prod_q;
  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: doc/pipelined_mac.md
Name: pipelined_mac

Overview:
- Parametrised successor to the fixed 8-bit, 2-stage unsigned multiplier.
- Multiplies two WIDTH-bit operands per cycle. Signedness is selectable per sample, latency is configurable, and each sample carries a valid flag.
- An optional accumulate path with a sticky overflow flag lets downstream datapath blocks use the same unit for dot products and filter taps.
- No backpressure: the unit accepts one sample every cycle.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- STAGES, 2, input-to-product latency in cycles (>=1). Pipeline registers are placed after the input capture.
- ACC_WIDTH, 2*WIDTH+8, accumulator width in bits (>=2*WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe; a, b and the sideband inputs are captured when it is high
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- acc_en  in  1  sample participates in the accumulator
- acc_clr  in  1  with acc_en: accumulator loads this product instead of adding it
- out_valid  out  1  product / acc valid this cycle
- product  out  2*WIDTH  full-precision product
- acc  out  ACC_WIDTH  running accumulator
- acc_ovf  out  1  sticky accumulator overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, product=0, acc=0, acc_ovf=0. Every pipeline valid bit and sideband register is cleared, so in-flight samples are discarded.
- Sideband tagging: a, b, signed_mode, acc_en and acc_clr travel through the pipeline as one tagged word.
  - Changing signed_mode between samples affects only later samples.
- Latency: a sample with in_valid high at rising edge N gives out_valid=1 and its product in the cycle after edge N+STAGES.
  - STAGES=2 keeps the legacy 2-cycle timing.
- Streaming: full throughput, one sample per cycle. Bubbles (in_valid=0) propagate unchanged, so the out_valid pattern equals the in_valid pattern delayed.
- Invalid stages: data registers may hold stale values, but product and acc do not change when out_valid=0. Both outputs hold their last value.
- Arithmetic:
  - Unsigned: zero-extend both operands to 2*WIDTH, then multiply.
  - Signed: sign-extend both operands, then multiply.
  - product is exact in both modes, with no overflow possible.
- Accumulator update: happens on the same edge that raises out_valid, for a final-stage sample with acc_en=1.
  - acc_clr=1: acc <= ext(product) and acc_ovf <= 0.
  - acc_clr=0: acc <= acc + ext(product), wrapping modulo 2^ACC_WIDTH.
  - ext() means sign-extend when the sample was signed, zero-extend otherwise.
- Overflow detection:
  - Unsigned sample: carry-out from the ACC_WIDTH-bit add.
  - Signed sample: both addends have equal sign and the result sign differs.
  - On overflow acc_ovf goes to 1 and stays set until an acc_clr sample or reset.
- Samples with acc_en=0 update product and out_valid only. acc and acc_ovf are untouched.
- Mixed-mode accumulation is the user's responsibility; overflow is judged by the current sample's mode.
- Reset mid-operation: asserting rst_n clears out_valid immediately, asynchronously. After release the first out_valid comes only from a sample presented after release.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, STAGES=2, unsigned: a=255, b=255 at edge N -> product=0xFE01, out_valid=1 after edge N+2 only.
- Signed: a=0x80, b=0x80 -> 0x4000; a=0xFF, b=0x01 -> 0xFFFF; same a=0xFF, b=0x01 unsigned -> 0x00FF. Send back-to-back and check per-sample mode tagging.
- Stream in_valid=1,1,0,1,0,0,1 with distinct operands -> identical out_valid pattern 2 cycles later, correct products in order, held outputs during bubbles.
- Accumulate: (3,4,clr) then (5,6) then (7,8,acc_en=0) -> acc=12, 42, 42; product of the third sample=56.
- Overflow: ACC_WIDTH=16, unsigned (255,255,clr) then (255,255) -> acc=0xFE01, then 0xFC02 with acc_ovf=1. A next (1,1,clr) -> acc=1, acc_ovf=0.
- Reset: assert rst_n low for 1 cycle while 2 samples are in flight -> outputs go to 0 asynchronously, and no out_valid follows until a new sample arrives after 2 cycles.
